// File: rtl/sort_loader.sv
// Feeds the mesh sorter: packs a valid/ready stream into init_values, then pulses
// sort_rst, waits a fixed sort duration and reports done before taking the next batch.
module sort_loader #(
  parameter int unsigned     WIDTH       = 8,
  parameter int unsigned     ROW         = 4,
  parameter int unsigned     COL         = 4,
  parameter int unsigned     SORT_CYCLES = 64,
  parameter logic [WIDTH-1:0] PAD_VALUE  = {WIDTH{1'b1}}
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [WIDTH-1:0]                   in_data,
  input  logic                               in_valid,
  input  logic                               in_last,
  output logic                               in_ready,
  output logic [WIDTH*ROW*COL-1:0]           init_values,
  output logic                               sort_rst,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(ROW*COL):0]           load_count
);

  localparam int unsigned N    = ROW * COL;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CntW = (SORT_CYCLES > 1) ? $clog2(SORT_CYCLES) : 1;
  localparam int unsigned LcW  = $clog2(N) + 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(SORT_CYCLES - 1);

  typedef enum logic [1:0] {StLoad, StKick, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [WIDTH*N-1:0]   values_q, values_d;
  logic [LcW-1:0]       load_count_q, load_count_d;
  logic                 sort_rst_q, sort_rst_d;
  logic                 done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StLoad;
      idx_q        <= '0;
      cnt_q        <= '0;
      values_q     <= '0;
      load_count_q <= '0;
      sort_rst_q   <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      values_q     <= values_d;
      load_count_q <= load_count_d;
      sort_rst_q   <= sort_rst_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    values_d     = values_q;
    load_count_d = load_count_q;
    sort_rst_d   = sort_rst_q;
    done_d       = 1'b0;
    in_ready     = 1'b0;
    busy         = 1'b1;

    unique case (state_q)
      StLoad: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          // First element of a batch pre-pads the rest so short batches sort last.
          if (idx_q == '0) begin
            for (int unsigned k = 1; k < N; k++) begin
              values_d[k*WIDTH +: WIDTH] = PAD_VALUE;
            end
          end
          values_d[int'(idx_q)*WIDTH +: WIDTH] = in_data;
          load_count_d = LcW'(idx_q) + LcW'(1);
          if (idx_q == LastIdx || in_last) begin
            idx_d      = '0;
            state_d    = StKick;
            sort_rst_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StKick: begin
        state_d    = StRun;
        sort_rst_d = 1'b0;
      end
      StRun: begin
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StLoad;
      end
      default: begin
        state_d = StLoad;
      end
    endcase
  end

  assign init_values = values_q;
  assign sort_rst    = sort_rst_q;
  assign done        = done_q;
  assign load_count  = load_count_q;

endmodule

// File: tb/tb_sort_loader.sv
// Directed bench for sort_loader with default parameters (8-bit, 4x4, 64 sort cycles).
module tb_sort_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [127:0] init_values;
  logic         sort_rst;
  logic         busy;
  logic         done;
  logic [4:0]   load_count;

  int unsigned  n_checks = 0;
  int unsigned  n_errors = 0;
  logic [127:0] exp_vals;

  sort_loader dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .init_values (init_values),
    .sort_rst    (sort_rst),
    .busy        (busy),
    .done        (done),
    .load_count  (load_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample/drive 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_elem(input int k, input logic [7:0] v);
    exp_vals[k*8 +: 8] = v;
  endtask

  // Present one element and hold it until accepted; valid stays high on return.
  task automatic send(input logic [7:0] d, input logic last);
    int  budget;
    logic acc;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    budget   = 0;
    acc      = 1'b0;
    while (!acc && budget < 300) begin
      acc = in_ready;
      step();
      budget++;
    end
    if (!acc) check("send_timeout", 128'd0, 128'd1);
  endtask

  // Called at the first cycle after the last accept; runs to the first LOAD cycle.
  task automatic run_sort(input string tag);
    int n, n_rst, n_done, done_at, bad_rdy, bad_vals;
    n = 0; n_rst = 0; n_done = 0; done_at = 0; bad_rdy = 0; bad_vals = 0;
    while (busy && n < 300) begin
      n++;
      if (sort_rst) n_rst++;
      if (done) begin n_done++; done_at = n; end
      if (in_ready) bad_rdy++;
      if (init_values !== exp_vals) bad_vals++;
      step();
    end
    check({tag, "_busy_cycles"}, 128'(n), 128'd66);
    check({tag, "_rst_cycles"}, 128'(n_rst), 128'd1);
    check({tag, "_done_count"}, 128'(n_done), 128'd1);
    check({tag, "_done_at"}, 128'(done_at), 128'd66);
    check({tag, "_ready_while_busy"}, 128'(bad_rdy), 128'd0);
    check({tag, "_values_unstable"}, 128'(bad_vals), 128'd0);
    check({tag, "_ready_after"}, 128'(in_ready), 128'd1);
    check({tag, "_sort_rst_after"}, 128'(sort_rst), 128'd0);
    check({tag, "_values_after"}, init_values, exp_vals);
  endtask

  initial begin
    int bad_rst, bad_done, bad_rdy;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    step(); step();
    check("rst_values", init_values, 128'd0);
    check("rst_load_count", 128'(load_count), 128'd0);
    check("rst_sort_rst", 128'(sort_rst), 128'd1);
    check("rst_done", 128'(done), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    rst = 1'b0;

    // Power-up idle.
    bad_rst = 0; bad_done = 0; bad_rdy = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!sort_rst) bad_rst++;
      if (done) bad_done++;
      if (!in_ready) bad_rdy++;
    end
    check("idle_sort_rst", 128'(bad_rst), 128'd0);
    check("idle_done", 128'(bad_done), 128'd0);
    check("idle_ready", 128'(bad_rdy), 128'd0);

    // Full batch 16..1, continuous valid.
    for (int k = 0; k < 16; k++) begin
      set_elem(k, 8'(16 - k));
      send(8'(16 - k), k == 15);
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("full_kick_ready", 128'(in_ready), 128'd0);
    check("full_kick_sort_rst", 128'(sort_rst), 128'd1);
    check("full_load_count", 128'(load_count), 128'd16);
    check("full_values", init_values, exp_vals);
    run_sort("full");

    // Short batch 5,3,9 with gaps in valid.
    exp_vals = {128{1'b1}};
    set_elem(0, 8'd5); set_elem(1, 8'd3); set_elem(2, 8'd9);
    send(8'd5, 1'b0); in_valid = 1'b0; step();
    send(8'd3, 1'b0); in_valid = 1'b0; step();
    send(8'd9, 1'b1);
    // Hold valid through the sort; it must wait for LOAD.
    in_data = 8'h42; in_last = 1'b0; in_valid = 1'b1;
    check("short_load_count", 128'(load_count), 128'd3);
    check("short_values", init_values, exp_vals);
    run_sort("short");

    // Back-to-back: held element is accepted in the first LOAD cycle.
    step();
    exp_vals = {128{1'b1}};
    set_elem(0, 8'h42);
    check("b2b_first_count", 128'(load_count), 128'd1);
    check("b2b_first_values", init_values, exp_vals);
    for (int k = 1; k < 16; k++) begin
      set_elem(k, 8'(k * 3));
      send(8'(k * 3), k == 15);
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("b2b_load_count", 128'(load_count), 128'd16);
    run_sort("b2b");

    // Reset at RUN count 20.
    for (int k = 0; k < 16; k++) send(8'(8'h20 + k), k == 15);
    in_valid = 1'b0; in_last = 1'b0;
    for (int i = 0; i < 21; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_values", init_values, 128'd0);
    check("mrst_sort_rst", 128'(sort_rst), 128'd1);
    check("mrst_busy", 128'(busy), 128'd0);
    check("mrst_load_count", 128'(load_count), 128'd0);
    check("mrst_done", 128'(done), 128'd0);
    check("mrst_ready", 128'(in_ready), 128'd1);
    for (int k = 0; k < 16; k++) begin
      set_elem(k, 8'(8'h80 + k));
      send(8'(8'h80 + k), 1'b0);
    end
    in_valid = 1'b0;
    check("fresh_load_count", 128'(load_count), 128'd16);
    run_sort("fresh");

    // Single-element batch.
    exp_vals = {128{1'b1}};
    set_elem(0, 8'h07);
    send(8'h07, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    check("single_load_count", 128'(load_count), 128'd1);
    run_sort("single");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
